// File: rtl/soc_sram_sp_pipelined_pkg.sv
// Shared types and helpers for the pipelined single-port tile SRAM.
package soc_sram_sp_pipelined_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sram_init_state_t;

  localparam int SRAM_RW_READ_FIRST  = 0;
  localparam int SRAM_RW_WRITE_FIRST = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/soc_sram_sp_array.sv
// Byte-enabled storage array with a one-cycle registered read port.
module soc_sram_sp_array
  import soc_sram_sp_pipelined_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MEM_WORDS = 4096,
  parameter int AW        = 12,
  parameter int RW_MODE   = SRAM_RW_READ_FIRST,
  localparam int SW       = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            rd_en,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  input  logic [SW-1:0]   sel,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [MEM_WORDS];
  logic [XLEN-1:0] merged;
  logic [XLEN-1:0] rdata_q, rdata_d;

  always_comb begin
    merged = mem[addr];
    for (int i = 0; i < SW; i++) begin
      if (sel[i]) merged[i*8 +: 8] = wdata[i*8 +: 8];
    end
  end

  // Write-first mode forwards the merged word so a write response shows the new contents.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = (RW_MODE == SRAM_RW_WRITE_FIRST && wr_en) ? merged : mem[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rdata_q <= '0;
    else      rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

  function automatic logic [XLEN-1:0] get_mem(input logic [AW-1:0] a);
    return mem[a];
  endfunction

endmodule

// File: rtl/soc_sram_sp_pipelined.sv
// Single-port tile SRAM with valid/ready requests, 1- or 2-cycle read latency and optional zero-fill.
module soc_sram_sp_pipelined
  import soc_sram_sp_pipelined_pkg::*;
#(
  parameter int PLEN          = 32,
  parameter int XLEN          = 32,
  parameter int MEM_SIZE_BYTE = 'h4000,
  parameter int READ_LATENCY  = 1,
  parameter int RW_MODE       = SRAM_RW_READ_FIRST,
  parameter int INIT_ZERO     = 0,
  localparam int SW           = XLEN / 8,
  localparam int WORD_AW      = PLEN - clog2(SW),
  localparam int MEM_WORDS    = MEM_SIZE_BYTE / SW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [WORD_AW-1:0] req_waddr,
  input  logic [XLEN-1:0]    req_din,
  input  logic [SW-1:0]      req_sel,
  output logic               rsp_valid,
  output logic [XLEN-1:0]    rsp_dout,
  output logic               rsp_err,
  output logic               init_done
);

  localparam int CNT_W = (clog2(MEM_WORDS) < 1) ? 1 : clog2(MEM_WORDS);
  localparam logic [WORD_AW:0] MEM_WORDS_W = (WORD_AW + 1)'(MEM_WORDS);

  sram_init_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_p1_q, vld_p1_d;
  logic             err_p1_q, err_p1_d;
  logic             accept, in_range;
  logic             arr_wr_en, arr_rd_en;
  logic [CNT_W-1:0] arr_addr;
  logic [XLEN-1:0]  arr_wdata, arr_rdata, dout_p1;
  logic [SW-1:0]    arr_sel;

  assign req_ready = (state_q == RUN);
  assign init_done = (state_q == RUN);
  assign accept    = req_valid & req_ready;
  assign in_range  = {1'b0, req_waddr} < MEM_WORDS_W;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_wr_en = 1'b0;
    arr_rd_en = 1'b0;
    arr_addr  = req_waddr[CNT_W-1:0];
    arr_wdata = req_din;
    arr_sel   = req_sel;
    vld_p1_d  = accept;
    err_p1_d  = err_p1_q;
    case (state_q)
      INIT: begin
        if (INIT_ZERO != 0) begin
          arr_wr_en = 1'b1;
          arr_addr  = cnt_q;
          arr_wdata = '0;
          arr_sel   = '1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MEM_WORDS - 1)) state_d = RUN;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Out-of-range requests still answer, but never touch the array.
        if (accept) begin
          err_p1_d  = ~in_range;
          arr_rd_en = in_range;
          arr_wr_en = in_range & req_we;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      vld_p1_q <= 1'b0;
      err_p1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_p1_q <= vld_p1_d;
      err_p1_q <= err_p1_d;
    end
  end

  soc_sram_sp_array #(
    .XLEN      (XLEN),
    .MEM_WORDS (MEM_WORDS),
    .AW        (CNT_W),
    .RW_MODE   (RW_MODE)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .wr_en (arr_wr_en),
    .rd_en (arr_rd_en),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .sel   (arr_sel),
    .rdata (arr_rdata)
  );

  assign dout_p1 = err_p1_q ? '0 : arr_rdata;

  // Stage 2: optional output register behind the array read register.
  if (READ_LATENCY == 2) begin : g_lat2
    logic            vld_p2_q, vld_p2_d;
    logic            err_p2_q, err_p2_d;
    logic [XLEN-1:0] dout_p2_q, dout_p2_d;

    always_comb begin
      vld_p2_d  = vld_p1_q;
      err_p2_d  = vld_p1_q ? err_p1_q : err_p2_q;
      dout_p2_d = vld_p1_q ? dout_p1  : dout_p2_q;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        vld_p2_q  <= 1'b0;
        err_p2_q  <= 1'b0;
        dout_p2_q <= '0;
      end else begin
        vld_p2_q  <= vld_p2_d;
        err_p2_q  <= err_p2_d;
        dout_p2_q <= dout_p2_d;
      end
    end

    assign rsp_valid = vld_p2_q;
    assign rsp_err   = err_p2_q;
    assign rsp_dout  = dout_p2_q;
  end else begin : g_lat1
    assign rsp_valid = vld_p1_q;
    assign rsp_err   = err_p1_q;
    assign rsp_dout  = dout_p1;
  end

endmodule

// File: tb/tb_soc_sram_sp_pipelined.sv
// Directed bench: latency-1/read-first and latency-2/write-first instances share one request stream.
module tb_soc_sram_sp_pipelined;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [29:0] req_waddr;
  logic [31:0] req_din;
  logic [3:0]  req_sel;

  logic        req_ready_a, rsp_valid_a, rsp_err_a, init_done_a;
  logic [31:0] rsp_dout_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, init_done_b;
  logic [31:0] rsp_dout_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  soc_sram_sp_pipelined #(
    .PLEN(32), .XLEN(32), .MEM_SIZE_BYTE(64),
    .READ_LATENCY(1), .RW_MODE(0), .INIT_ZERO(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_a), .req_we(req_we),
    .req_waddr(req_waddr), .req_din(req_din), .req_sel(req_sel),
    .rsp_valid(rsp_valid_a), .rsp_dout(rsp_dout_a), .rsp_err(rsp_err_a),
    .init_done(init_done_a)
  );

  soc_sram_sp_pipelined #(
    .PLEN(32), .XLEN(32), .MEM_SIZE_BYTE(64),
    .READ_LATENCY(2), .RW_MODE(1), .INIT_ZERO(1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_b), .req_we(req_we),
    .req_waddr(req_waddr), .req_din(req_din), .req_sel(req_sel),
    .rsp_valid(rsp_valid_b), .rsp_dout(rsp_dout_b), .rsp_err(rsp_err_b),
    .init_done(init_done_b)
  );

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] din;
    logic [3:0]  sel;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        err;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n, output int pulses);
    n = 0;
    pulses = 0;
    do begin
      step();
      n++;
      if (rsp_valid_a || rsp_valid_b) pulses++;
    end while (!req_ready_a && n < 100);
  endtask

  task automatic drive(input logic we, input logic [29:0] addr, input logic [31:0] din,
                       input logic [3:0] sel);
    req_valid = 1'b1;
    req_we    = we;
    req_waddr = addr;
    req_din   = din;
    req_sel   = sel;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pulses;
    vecs[0]  = '{1'b0, 30'd5,          32'h0,        4'h0, 32'h0,        32'h0,        1'b0};
    vecs[1]  = '{1'b1, 30'd3,          32'h11223344, 4'hF, 32'h0,        32'h11223344, 1'b0};
    vecs[2]  = '{1'b1, 30'd3,          32'hAABBCCDD, 4'h5, 32'h11223344, 32'h11BB33DD, 1'b0};
    vecs[3]  = '{1'b0, 30'd3,          32'h0,        4'h0, 32'h11BB33DD, 32'h11BB33DD, 1'b0};
    vecs[4]  = '{1'b1, 30'd7,          32'h12345678, 4'hF, 32'h0,        32'h12345678, 1'b0};
    vecs[5]  = '{1'b1, 30'd7,          32'hCAFEF00D, 4'hF, 32'h12345678, 32'hCAFEF00D, 1'b0};
    vecs[6]  = '{1'b0, 30'd7,          32'h0,        4'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[7]  = '{1'b1, 30'd3,          32'hFFFFFFFF, 4'h0, 32'h11BB33DD, 32'h11BB33DD, 1'b0};
    vecs[8]  = '{1'b0, 30'd3,          32'h0,        4'h0, 32'h11BB33DD, 32'h11BB33DD, 1'b0};
    vecs[9]  = '{1'b0, 30'd16,         32'h0,        4'h0, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 30'd16,         32'hDEADBEEF, 4'hF, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b0, 30'd0,          32'h0,        4'h0, 32'h0,        32'h0,        1'b0};
    vecs[12] = '{1'b1, 30'd15,         32'h0F0F0F0F, 4'hF, 32'h0,        32'h0F0F0F0F, 1'b0};
    vecs[13] = '{1'b0, 30'd15,         32'h0,        4'h0, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0};
    vecs[14] = '{1'b0, 30'h3FFFFFFF,   32'h0,        4'h0, 32'h0,        32'h0,        1'b1};

    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_waddr = '0; req_din = '0; req_sel = '0;
    repeat (3) step();
    chk("rst_ready_a", {31'b0, req_ready_a}, 32'd0);
    chk("rst_ready_b", {31'b0, req_ready_b}, 32'd0);
    chk("rst_done_a",  {31'b0, init_done_a}, 32'd0);
    chk("rst_done_b",  {31'b0, init_done_b}, 32'd0);
    chk("rst_vld_a",   {31'b0, rsp_valid_a}, 32'd0);
    chk("rst_vld_b",   {31'b0, rsp_valid_b}, 32'd0);
    chk("rst_err_a",   {31'b0, rsp_err_a},   32'd0);
    chk("rst_err_b",   {31'b0, rsp_err_b},   32'd0);
    chk("rst_dout_a",  rsp_dout_a, 32'd0);
    chk("rst_dout_b",  rsp_dout_b, 32'd0);

    rst = 1'b1;
    wait_ready(n, pulses);
    chk("init_cycles", n, 32'd16);
    chk("init_ready_b", {31'b0, req_ready_b}, 32'd1);
    chk("init_done_a",  {31'b0, init_done_a}, 32'd1);
    chk("init_done_b",  {31'b0, init_done_b}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].din, vecs[i].sel);
      step();
      req_valid = 1'b0;
      chk($sformatf("v%0d_vld_a", i),  {31'b0, rsp_valid_a}, 32'd1);
      chk($sformatf("v%0d_dout_a", i), rsp_dout_a, vecs[i].exp_a);
      chk($sformatf("v%0d_err_a", i),  {31'b0, rsp_err_a}, {31'b0, vecs[i].err});
      chk($sformatf("v%0d_early_b", i), {31'b0, rsp_valid_b}, 32'd0);
      step();
      chk($sformatf("v%0d_drop_a", i), {31'b0, rsp_valid_a}, 32'd0);
      chk($sformatf("v%0d_hold_a", i), rsp_dout_a, vecs[i].exp_a);
      chk($sformatf("v%0d_vld_b", i),  {31'b0, rsp_valid_b}, 32'd1);
      chk($sformatf("v%0d_dout_b", i), rsp_dout_b, vecs[i].exp_b);
      chk($sformatf("v%0d_err_b", i),  {31'b0, rsp_err_b}, {31'b0, vecs[i].err});
      step();
      chk($sformatf("v%0d_drop_b", i), {31'b0, rsp_valid_b}, 32'd0);
      chk($sformatf("v%0d_hold_b", i), rsp_dout_b, vecs[i].exp_b);
    end

    // Back-to-back: write 9, read 9, read 3 on consecutive cycles.
    drive(1'b1, 30'd9, 32'h5A5A5A5A, 4'hF);
    step();
    chk("b2b_w_vld_a",  {31'b0, rsp_valid_a}, 32'd1);
    chk("b2b_w_dout_a", rsp_dout_a, 32'h0);
    drive(1'b0, 30'd9, 32'h0, 4'h0);
    step();
    chk("b2b_r9_vld_a",  {31'b0, rsp_valid_a}, 32'd1);
    chk("b2b_r9_dout_a", rsp_dout_a, 32'h5A5A5A5A);
    chk("b2b_w_vld_b",   {31'b0, rsp_valid_b}, 32'd1);
    chk("b2b_w_dout_b",  rsp_dout_b, 32'h5A5A5A5A);
    drive(1'b0, 30'd3, 32'h0, 4'h0);
    step();
    req_valid = 1'b0;
    chk("b2b_r3_vld_a",  {31'b0, rsp_valid_a}, 32'd1);
    chk("b2b_r3_dout_a", rsp_dout_a, 32'h11BB33DD);
    chk("b2b_r9_vld_b",  {31'b0, rsp_valid_b}, 32'd1);
    chk("b2b_r9_dout_b", rsp_dout_b, 32'h5A5A5A5A);
    step();
    chk("b2b_end_vld_a", {31'b0, rsp_valid_a}, 32'd0);
    chk("b2b_r3_vld_b",  {31'b0, rsp_valid_b}, 32'd1);
    chk("b2b_r3_dout_b", rsp_dout_b, 32'h11BB33DD);
    step();
    chk("b2b_end_vld_b", {31'b0, rsp_valid_b}, 32'd0);

    // Reset from RUN, then abort the fill at cnt=7 and restart it.
    rst = 1'b0;
    #1;
    chk("rerst_dout_a",  rsp_dout_a, 32'h0);
    chk("rerst_dout_b",  rsp_dout_b, 32'h0);
    chk("rerst_ready_a", {31'b0, req_ready_a}, 32'd0);
    step();
    rst = 1'b1;
    repeat (7) step();
    chk("mid_ready_a", {31'b0, req_ready_a}, 32'd0);
    rst = 1'b0;
    drive(1'b1, 30'd3, 32'hFFFFFFFF, 4'hF);
    #1;
    chk("abort_done_a", {31'b0, init_done_a}, 32'd0);
    step();
    rst = 1'b1;
    wait_ready(n, pulses);
    req_valid = 1'b0;
    chk("restart_cycles", n, 32'd16);
    chk("init_ignored_pulses", pulses, 32'd0);
    chk("restart_done_b", {31'b0, init_done_b}, 32'd1);

    drive(1'b0, 30'd3, 32'h0, 4'h0);
    step();
    req_valid = 1'b0;
    chk("refill_vld_a",  {31'b0, rsp_valid_a}, 32'd1);
    chk("refill_dout_a", rsp_dout_a, 32'h0);
    step();
    chk("refill_vld_b",  {31'b0, rsp_valid_b}, 32'd1);
    chk("refill_dout_b", rsp_dout_b, 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_sram_sp_pipelined.md
Name: soc_sram_sp_pipelined

Overview:
Parametrised single-port block SRAM for the optimsoc tile memory path. It adds the following over the plain single-port SRAM:
- any data width that is a multiple of 8
- a valid/ready request handshake with a response-valid strobe
- selectable read latency of 1 or 2
- selectable read-first or write-first behaviour
- out-of-range address error flagging
- an optional post-reset zero-fill state machine

It sits between the bus-to-memory adapter and the storage array.

Parameters:
PLEN, 32, byte address width
XLEN, 32, data width; must be a multiple of 8 and at least 8
SW, XLEN/8, localparam: byte lanes per word
WORD_AW, PLEN-clog2(SW), word address width
MEM_SIZE_BYTE, 'h4000, memory size in bytes; must be a multiple of SW
MEM_WORDS, MEM_SIZE_BYTE/SW, localparam: depth in words
READ_LATENCY, 1, cycles from request acceptance to response; legal values are 1 and 2 only
RW_MODE, 0, write-cycle response data: 0 = read-first (old data), 1 = write-first (merged new data)
INIT_ZERO, 0, 1 = zero-fill every word after reset before accepting requests
MEM_FILE, "sram.vmem", simulation init file; not loaded when INIT_ZERO=1

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = write, 0 = read
req_waddr  in  WORD_AW  word address
req_din  in  XLEN  write data
req_sel  in  SW  byte-lane write enables
rsp_valid  out  1  response strobe, single cycle
rsp_dout  out  XLEN  response data
rsp_err  out  1  accepted address was >= MEM_WORDS
init_done  out  1  initialisation finished

Behaviour:
- Reset is asynchronous, active-low. While rst=0 the following are all 0:
  - req_ready, rsp_valid, rsp_dout, rsp_err, init_done
  - FSM state INIT, init counter
  - pipeline valid bits
- Array contents are never reset by rst.
- FSM has two states, INIT and RUN.
- INIT with INIT_ZERO=1:
  - Writes all-zero to address cnt each cycle, cnt = 0..MEM_WORDS-1.
  - On cnt = MEM_WORDS-1, transitions to RUN on the next edge. Total time is MEM_WORDS cycles after the first edge following reset release.
- INIT with INIT_ZERO=0: transitions to RUN on the first edge after reset release.
- RUN:
  - init_done=1 and req_ready=1 permanently.
  - No response backpressure; a request can be accepted every cycle.
- Reset asserted mid-INIT aborts the fill; it restarts from cnt=0 after release.
- Accept condition: req_valid & req_ready. Inputs are ignored in any other cycle.
- Write with an in-range address updates only the lanes where req_sel[i]=1. req_sel=0 writes nothing but still produces a response.
- Out-of-range address (req_waddr >= MEM_WORDS):
  - No array access.
  - Response carries rsp_dout=0 and rsp_err=1.
  - rsp_err is otherwise 0.
- Response timing:
  - Every accepted request, read or write, produces exactly one rsp_valid pulse.
  - The pulse occurs READ_LATENCY edges after acceptance, and responses stay in order.
  - With READ_LATENCY=2, an output register sits after the array read register.
- rsp_dout on a read is the word at the address after all earlier accepted writes. Back-to-back write-then-read to the same address returns the new data.
- rsp_dout on a write: RW_MODE=0 returns the pre-write word; RW_MODE=1 returns the merged post-write word.
- rsp_dout and rsp_err hold their last value while rsp_valid=0.

Decomposition:
- Package soc_optimsoc_functions (existing) supplies clog2.
- Add to the shared package:
  - enum sram_init_state_t {INIT, RUN}
  - constants SRAM_RW_READ_FIRST=0 and SRAM_RW_WRITE_FIRST=1
- One sub-module, soc_sram_sp_array:
  - byte-enabled storage with a 1-cycle registered read and RW_MODE forwarding
  - Verilator DPI hooks (do_readmemh, do_readmemh_file, get_mem, set_mem)
- The top level holds the FSM, range check, request handshake and latency pipeline.

Test Plan:
1. INIT_ZERO=1, MEM_SIZE_BYTE=64, XLEN=32, release rst -> req_ready=0 for 16 cycles, then init_done=1 and req_ready=1; a read of addr 5 returns 0.
2. Write addr 3, din=32'hAABBCCDD, sel=4'b0101 over a prior 32'h11223344, then read addr 3 -> rsp_dout=32'h11BB33DD, rsp_valid exactly READ_LATENCY cycles after each accept.
3. RW_MODE=0 vs 1: write 32'hCAFEF00D over 32'h12345678 with sel=4'hF -> write response 32'h12345678 (mode 0) or 32'hCAFEF00D (mode 1).
4. Read of addr 16 with MEM_WORDS=16 -> rsp_err=1 and rsp_dout=0; the array is unchanged.
5. READ_LATENCY=2: back-to-back accepts of write A, read A, read B -> three consecutive rsp_valid pulses in order; the read of A returns the new data.
6. Assert rst at cnt=7 during INIT, then release -> the fill restarts from 0 and init_done rises 16 cycles after release.
